// File: rtl/rapid_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// rapid_pipeline_ctrl
//
// Pipeline sequencer for the rapid multicycle CPU. It waits until every stage
// reports done (and nothing external is holding the pipe), then issues a
// one-cycle advance pulse to all stages. It also tracks which stages hold
// valid work, squashes every stage after a redirect, and runs a watchdog that
// parks the FSM in TIMEOUT when the pipe stops making progress.
//
// Parameters:
//   NUM_STAGES  number of handshaking stages (2..8); index 0 is the youngest
//   TIMEOUT_W   width of the watchdog limit and wait counter
//   CNT_W       width of the performance counters
//
// Ports:
//   i_clk            clock, all logic on its rising edge
//   i_reset_n        synchronous active-low reset
//   i_stage_done     per-stage done levels
//   i_stall_req      external hold, blocks advance
//   i_flush_req      redirect request, sampled only when advance is granted
//   i_timeout_limit  watchdog limit in wait cycles, 0 disables the watchdog
//   i_timeout_clr    leaves the TIMEOUT state
//   o_advance        one-cycle advance pulse to every stage
//   o_flush          one-cycle squash strobe, one bit per stage
//   o_stage_valid    per-stage valid bits
//   o_state          WAIT=0, ADV=1, FLUSH=2, TIMEOUT=3
//   o_timeout        high while in TIMEOUT
//   o_cycle_cnt      cycles out of reset
//   o_retire_cnt     advances that pushed valid work out of the oldest stage
//   o_stall_cnt      cycles spent in WAIT or TIMEOUT
//
// Build option:
//   RAPID_PERF_COUNTERS_EN  when defined the three performance counters are
//                           built; otherwise they read as constant 0.
// -----------------------------------------------------------------------------
module rapid_pipeline_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT_W  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  input  logic                  i_stall_req,
  input  logic                  i_flush_req,
  input  logic [TIMEOUT_W-1:0]  i_timeout_limit,
  input  logic                  i_timeout_clr,
  output logic                  o_advance,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic [NUM_STAGES-1:0] o_stage_valid,
  output logic [1:0]            o_state,
  output logic                  o_timeout,
  output logic [CNT_W-1:0]      o_cycle_cnt,
  output logic [CNT_W-1:0]      o_retire_cnt,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_ADV     = 2'd1,
    S_FLUSH   = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t                  state;
  logic [TIMEOUT_W-1:0]    wait_cnt;
  logic                    flush_q;
  logic [NUM_STAGES-1:0]   valid;
  logic                    advance_r;
  logic [NUM_STAGES-1:0]   flush_r;
  logic                    timeout_r;

  logic                    advance_go;
  logic [TIMEOUT_W-1:0]    wait_next;
  logic                    watchdog_hit;

  // Advance is only ever granted from WAIT, so a done level that lingers
  // through ADV cannot produce a second pulse.
  assign advance_go   = (state == S_WAIT) && (&i_stage_done) && !i_stall_req;
  assign wait_next    = wait_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign watchdog_hit = (i_timeout_limit != '0) && (wait_next == i_timeout_limit);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= S_WAIT;
      wait_cnt  <= '0;
      flush_q   <= 1'b0;
      valid     <= '0;
      advance_r <= 1'b0;
      flush_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      advance_r <= 1'b0;
      flush_r   <= '0;
      case (state)
        S_WAIT: begin
          if (advance_go) begin
            state     <= S_ADV;
            advance_r <= 1'b1;
            wait_cnt  <= '0;
            valid     <= {valid[NUM_STAGES-2:0], 1'b1};
            flush_q   <= i_flush_req;
          end else if (watchdog_hit) begin
            state     <= S_TIMEOUT;
            timeout_r <= 1'b1;
          end else begin
            wait_cnt  <= wait_next;
          end
        end
        S_ADV: begin
          flush_q <= 1'b0;
          if (flush_q) begin
            state   <= S_FLUSH;
            flush_r <= '1;
          end else begin
            state   <= S_WAIT;
          end
        end
        S_FLUSH: begin
          // Stage 0 is squashed too: its fetch belongs to the old PC.
          valid <= '0;
          state <= S_WAIT;
        end
        S_TIMEOUT: begin
          if (i_timeout_clr) begin
            state     <= S_WAIT;
            timeout_r <= 1'b0;
            wait_cnt  <= '0;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign o_advance     = advance_r;
  assign o_flush       = flush_r;
  assign o_stage_valid = valid;
  assign o_state       = state;
  assign o_timeout     = timeout_r;

`ifdef RAPID_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Retirement is judged on the pre-shift oldest valid bit, i.e. the entry
  // that this advance pushes out of the pipe.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (advance_go && valid[NUM_STAGES-1])
        retire_cnt <= retire_cnt + 1'b1;
      if ((state == S_WAIT) || (state == S_TIMEOUT))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_cycle_cnt  = cycle_cnt;
  assign o_retire_cnt = retire_cnt;
  assign o_stall_cnt  = stall_cnt;
`else
  assign o_cycle_cnt  = '0;
  assign o_retire_cnt = '0;
  assign o_stall_cnt  = '0;
`endif

endmodule

// File: doc/rapid_pipeline_ctrl.md
# rapid_pipeline_ctrl

Parametrised pipeline sequencer for the rapid multicycle CPU. It generalises the fixed three-stage `done`-AND handshake to `NUM_STAGES` stages and drives a single-cycle `o_advance` pulse to every stage. It also tracks per-stage valid bits, squashes wrong-path work on a redirect, and detects a hung pipeline with a watchdog. It sits between the IF/DE/EX/… stage `o_done` outputs and their `i_pipeline_ready` inputs; EX's `o_pc_load` feeds `i_flush_req`.

## Interface
- `NUM_STAGES`, default 3: number of handshaking stages. Index 0 is the youngest (IF) and `NUM_STAGES-1` is the oldest. Legal range is 2..8.
- `TIMEOUT_W`, default 16: width of the watchdog limit and counter.
- `CNT_W`, default 32: width of the performance counters.
- `i_clk`, in, 1: the single clock. All logic is on its rising edge.
- `i_reset_n`, in, 1: synchronous, active-low reset.
- `i_stage_done`, in, `NUM_STAGES`: per-stage done level.
- `i_stall_req`, in, 1: external hold (e.g. memory busy). It blocks advance.
- `i_flush_req`, in, 1: redirect request. It is sampled only on the cycle that advance is granted.
- `i_timeout_limit`, in, `TIMEOUT_W`: watchdog limit in wait cycles. A value of 0 disables the watchdog.
- `i_timeout_clr`, in, 1: leaves the TIMEOUT state.
- `o_advance`, out, 1: one-cycle pipeline-ready pulse.
- `o_flush`, out, `NUM_STAGES`: one-cycle squash strobe, one bit per stage.
- `o_stage_valid`, out, `NUM_STAGES`: per-stage valid bits.
- `o_state`, out, 2: current state. WAIT=0, ADV=1, FLUSH=2, TIMEOUT=3.
- `o_timeout`, out, 1: high while in TIMEOUT.
- `o_cycle_cnt`, `o_retire_cnt`, `o_stall_cnt`, out, `CNT_W` each: performance counters.

## Operation
State machine:
- **WAIT**
  - Go to ADV when all bits of `i_stage_done` are 1 and `i_stall_req` is 0.
  - Otherwise go to TIMEOUT when `i_timeout_limit != 0` and `wait_cnt + 1 == i_timeout_limit`.
  - Otherwise stay in WAIT and increment `wait_cnt`.
  - Advance has priority over timeout in the same cycle.
- **ADV**
  - `o_advance` is 1 for this cycle.
  - `i_stage_done` is ignored, so a lingering `done` cannot cause a double advance.
  - Next state is FLUSH if the latched flush is set, else WAIT.
- **FLUSH**
  - `o_flush` is all-ones for this cycle.
  - `o_stage_valid` is cleared to 0 at the edge leaving FLUSH.
  - Next state is WAIT.
- **TIMEOUT**
  - `o_timeout` is 1 and no advance is issued.
  - Go to WAIT on `i_timeout_clr`; `wait_cnt` is zeroed on that exit.

Datapath behaviour:
- `wait_cnt` is cleared on every entry to ADV.
- Valid shift happens at the WAIT→ADV edge: `valid[0] <= 1` and `valid[k] <= valid[k-1]` for k ≥ 1.
- At the same WAIT→ADV edge, `i_flush_req` is latched into `flush_q`. `flush_q` is cleared on the next edge.
- `o_retire_cnt` increments at the WAIT→ADV edge when the pre-shift `valid[NUM_STAGES-1]` is 1.
- A flush clears every valid bit, including stage 0: the IF result in flight belongs to the old PC.
- Counters wrap modulo 2^`CNT_W`.
  - `o_cycle_cnt` increments every cycle out of reset.
  - `o_stall_cnt` increments every cycle spent in WAIT or TIMEOUT.

Reset (`i_reset_n` = 0 at an edge):
- Next state is WAIT.
- All outputs are 0, and `wait_cnt`, `flush_q` and all counters are 0.
- Reset overrides every in-progress transition, including a pending flush.

## Timing
- `done` all-high and `stall` low sampled at edge N → `o_advance` = 1 during cycle N..N+1, and `o_stage_valid` is updated at edge N.
- Minimum advance spacing is 2 cycles without a flush and 3 cycles with a flush.
- `o_flush` is asserted in the cycle immediately after `o_advance`.
- Timeout fires after exactly `i_timeout_limit` consecutive WAIT cycles. The first TIMEOUT cycle follows the edge at which the `limit`-th wait is observed.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- `i_timeout_limit` may change at any time. The comparison always uses the current value.

## Configuration
- `RAPID_PERF_COUNTERS_EN` defined: `o_cycle_cnt`, `o_retire_cnt` and `o_stall_cnt` are implemented as described.
- `RAPID_PERF_COUNTERS_EN` undefined: no counter flops are built and the three outputs are tied to 0. The FSM, valid bits, flush and watchdog behaviour are unchanged.

## Test plan
- **Reset:** hold `i_reset_n`=0 for 2 cycles, then release → `o_state`=0 and `o_advance`/`o_flush`/`o_stage_valid`/counters are 0; `i_stage_done`=3'b111 then yields `o_advance` high for exactly 1 cycle.
- **Fill and retire:** with `NUM_STAGES`=3, hold `done`=all-ones continuously → `o_advance` every 2nd cycle; `o_stage_valid` goes 001, 011, 111; `o_retire_cnt` is 1 after the 4th advance.
- **Flush:** with valid=111, assert `i_flush_req` together with `done` → ADV, then FLUSH with `o_flush`=111; valid=000; next advance gives valid=001; no retire is counted for the squashed entries.
- **Stall and partial done:** `done`=3'b101 for 5 cycles, then 111 with `i_stall_req`=1 for 3 cycles → no advance and `o_stall_cnt` increases by 8; dropping the stall advances at the next edge.
- **Watchdog:** `i_timeout_limit`=4 with `done`=0 → `o_timeout` rises after 4 WAIT cycles and holds; `i_timeout_clr` returns the FSM to WAIT; with `i_timeout_limit`=0, 1000 idle cycles cause no timeout.
- **Mid-operation reset:** assert reset during ADV with `flush_q`=1 → next cycle `o_flush`=0, state is WAIT and valid=0; run once with `RAPID_PERF_COUNTERS_EN` undefined and confirm the counters read 0.
